// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM state encoding and datapath select codes for multicycle_control.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pcsrc_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        aluop_t     alu_op;
        pcsrc_t     pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> multicycle datapath bundle; timeout exists only with MEM_TIMEOUT_EN.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
    logic IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]          ALUSrcB, ALUOp, PCSource;
    logic [3:0]          state;
    logic                instr_done;
    logic                illegal_op;
    logic [CNT_W-1:0]    instr_count;
`ifdef MEM_TIMEOUT_EN
    logic                timeout;
`endif

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, state, instr_done, illegal_op, instr_count
`ifdef MEM_TIMEOUT_EN
        , output timeout
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, state, instr_done, illegal_op, instr_count
`ifdef MEM_TIMEOUT_EN
        , input timeout
`endif
    );

endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational strobe decode from the registered state, mem_ready and latched opcode.
module ctrl_out_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_t              state,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE:    ctl.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctl.mem_write  = 1'b1;
                ctl.iord       = 1'b1;
                ctl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a        = 1'b1;
                ctl.alu_op           = ALU_SUB;
                ctl.pc_source        = PC_ALUOUT;
                ctl.pc_write_cond    = (opcode == OP_BEQ);
                ctl.pc_write_cond_ne = (opcode == OP_BNE);
                ctl.instr_done       = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PC_JUMP;
                ctl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = (opcode == OP_ADDI) ? ALU_ADD : ALU_IMM;
            end
            S_I_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_TRAP:      ctl.illegal_op = 1'b1;
            default:     ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with retired-instruction counter and illegal-opcode trap.
// Define MEM_TIMEOUT_EN to trap when a memory wait reaches MEM_TIMEOUT cycles.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic Clk,
    input logic Rst,
    multicycle_control_if.master bus
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    count_q;
    ctrl_t               ctl;

    // The IR opcode is only trusted in DECODE, so later states use this copy.
    ctrl_out_decode #(.OPCODE_W(OPCODE_W)) u_dec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .opcode    (op_q),
        .ctl       (ctl)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;
    logic              waiting, expire;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign expire  = waiting && !bus.mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_RTYPE:                 state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
`ifdef MEM_TIMEOUT_EN
        if (expire) state_d = S_TRAP;
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= bus.opcode;
            if (ctl.instr_done) count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Any state change clears the count, which covers entry into each wait state.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) wait_q <= '0;
            else if (waiting && !bus.mem_ready) wait_q <= wait_q + WAIT_W'(1);
            if (expire) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`endif

    assign bus.PCWrite       = ctl.pc_write;
    assign bus.PCWriteCond   = ctl.pc_write_cond;
    assign bus.PCWriteCondNe = ctl.pc_write_cond_ne;
    assign bus.IorD          = ctl.iord;
    assign bus.MemRead       = ctl.mem_read;
    assign bus.MemWrite      = ctl.mem_write;
    assign bus.IRWrite       = ctl.ir_write;
    assign bus.MemtoReg      = ctl.mem_to_reg;
    assign bus.RegDst        = ctl.reg_dst;
    assign bus.RegWrite      = ctl.reg_write;
    assign bus.ALUSrcA       = ctl.alu_src_a;
    assign bus.ALUSrcB       = ctl.alu_src_b;
    assign bus.ALUOp         = ctl.alu_op;
    assign bus.PCSource      = ctl.pc_source;
    assign bus.state         = state_q;
    assign bus.instr_done    = ctl.instr_done;
    assign bus.illegal_op    = ctl.illegal_op;
    assign bus.instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/strobes/count queued at drive time.
module tb_multicycle_control;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    always #5 Clk = ~Clk;

    multicycle_control_if #(.OPCODE_W(6), .CNT_W(32)) bus ();

    multicycle_control #(.OPCODE_W(6), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  st;
        logic [18:0] outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = '0;
    logic [5:0]  cur_op = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected strobes per state; bit order matches the monitor's packing.
    function automatic logic [18:0] exp_out(input logic [3:0] st, input logic mr, input logic [5:0] op);
        logic pcw, pwc, pwcn, iord, mrd, mw, irw, m2r, rd, rw, asa, done, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pwc, pwcn, iord, mrd, mw, irw, m2r, rd, rw, asa, done, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; done = 1; end
            4'd6:  begin mw = 1; iord = 1; done = mr; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rd = 1; done = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; done = 1;
                         pwc = (op == 6'b000100); pwcn = (op == 6'b000101); end
            4'd10: begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd11: begin asa = 1; asb = 2'b10; aop = (op == 6'b001000) ? 2'b00 : 2'b11; end
            4'd12: begin rw = 1; done = 1; end
            4'd13: ill = 1;
            default: ;
        endcase
        return {pcw, pwc, pwcn, iord, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, done, ill};
    endfunction

    task automatic step(input logic rst, input logic mr, input logic [5:0] op, input logic [3:0] st);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst           = rst;
        bus.mem_ready = mr;
        bus.opcode    = op;
        e.st   = st;
        e.outs = exp_out(st, mr, cur_op);
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (st == 4'd2) cur_op = op;
        if (!rst) exp_cnt = '0;
        else if (e.outs[1]) exp_cnt = exp_cnt + 32'd1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic instr(input logic [5:0] op, input int unsigned fs, input int unsigned ms);
        for (int unsigned i = 0; i < fs; i++) step(1, 0, op, 4'd1);
        step(1, 1, op, 4'd1);
        step(1, rnd(), op, 4'd2);
        case (op)
            6'b100011: begin
                step(1, rnd(), op, 4'd3);
                for (int unsigned i = 0; i < ms; i++) step(1, 0, op, 4'd4);
                step(1, 1, op, 4'd4);
                step(1, rnd(), op, 4'd5);
            end
            6'b101011: begin
                step(1, rnd(), op, 4'd3);
                for (int unsigned i = 0; i < ms; i++) step(1, 0, op, 4'd6);
                step(1, 1, op, 4'd6);
            end
            6'b000000: begin step(1, rnd(), op, 4'd7); step(1, rnd(), op, 4'd8); end
            6'b000100, 6'b000101: step(1, rnd(), op, 4'd9);
            6'b000010: step(1, rnd(), op, 4'd10);
            6'b001000, 6'b001100, 6'b001101: begin
                step(1, rnd(), op, 4'd11);
                step(1, rnd(), op, 4'd12);
            end
            default: for (int unsigned i = 0; i < 10; i++) step(1, rnd(), op, 4'd13);
        endcase
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state", 64'(bus.state), 64'(e.st));
            check("strobes", 64'({bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNe, bus.IorD,
                                  bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                                  bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                                  bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal_op}),
                  64'(e.outs));
            check("instr_count", 64'(bus.instr_count), 64'(e.cnt));
        end
    end

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;

        for (int i = 0; i < 3; i++) step(0, rnd(), 6'b000000, 4'd0);
        step(1, 0, 6'b000000, 4'd0);

        instr(6'b100011, 2, 2);
        instr(6'b000000, 0, 0);
        instr(6'b000100, 0, 0);
        instr(6'b000101, 0, 0);
        instr(6'b000010, 0, 0);
        instr(6'b001100, 0, 0);
        instr(6'b001000, 1, 0);
        instr(6'b001101, 0, 0);
        instr(6'b101011, 0, 1);
        instr(6'b101011, 0, 0);

        instr(6'b111111, 0, 0);
        step(0, rnd(), 6'b111111, 4'd13);
        step(1, 0, 6'b000000, 4'd0);

`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) step(1, 0, 6'b000000, 4'd1);
        for (int i = 0; i < 3; i++) step(1, rnd(), 6'b000000, 4'd13);
        @(negedge Clk);
        #1;
        check("timeout", 64'(bus.timeout), 64'd1);
`else
        for (int i = 0; i < 100; i++) step(1, 0, 6'b000000, 4'd1);
        instr(6'b000010, 0, 0);
`endif

        @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
